// File: rtl/exc_seq.sv
// exc_seq -- exception / interrupt / ERET sequencer for the 5-stage pipeline.
//
// Arbitrates synchronous exception requests, the cp0 interrupt request and
// ERET at the MEM stage. Waits for any in-flight bus access to finish, then
// flushes IF..MEM, drives the cp0 EXL/ExcCode/pc controls for one cycle and
// redirects fetch to the common handler (exception/interrupt) or to EPC (ERET).
// A short guard window afterwards ignores new requests so that the cp0
// interrupt request has time to de-assert.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   exc_req      per-source synchronous exception request (index 0 wins)
//   exc_codes    per-source ExcCode, source i in bits [5i+4:5i]
//   int_req      interrupt request from cp0
//   eret_m       ERET in MEM stage
//   mem_busy     bus transaction in flight; flush must wait while high
//   pc_m         PC of the MEM-stage instruction
//   epc_i        EPC from cp0 (used as redirect target in RET)
//   stall        freeze the pipeline
//   flush        kill IF, ID, EX and MEM contents
//   redirect     load fetch PC from redirect_pc
//   redirect_pc  new fetch address
//   exl_set      cp0 EXLSet
//   exl_clr      cp0 EXLClr
//   exc_code     cp0 ExcCode (0 for interrupts)
//   cp0_pc       victim PC + 4; cp0 subtracts 4 to record EPC
module exc_seq #(
  parameter int          NSRC         = 4,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          GUARD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   exc_req,
  input  logic [NSRC*5-1:0] exc_codes,
  input  logic              int_req,
  input  logic              eret_m,
  input  logic              mem_busy,
  input  logic [31:0]       pc_m,
  input  logic [31:0]       epc_i,
  output logic              stall,
  output logic              flush,
  output logic              redirect,
  output logic [31:0]       redirect_pc,
  output logic              exl_set,
  output logic              exl_clr,
  output logic [4:0]        exc_code,
  output logic [31:0]       cp0_pc
);

  localparam int CNT_W = (GUARD_CYCLES < 1) ? 1 : $clog2(GUARD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    TAKE  = 3'd2,
    RET   = 3'd3,
    GUARD = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       code_q, code_nxt;
  logic [31:0]      vpc_q, vpc_nxt;
  logic             is_ret_q, is_ret_nxt;   // captured request is an ERET
  logic [CNT_W-1:0] cnt_q, cnt_nxt;

  logic             exc_any;
  logic [4:0]       exc_sel_code;
  logic             req_any;
  logic             req_is_ret;

  // Address cp0 must receive so that it stores the victim PC as EPC.
  // Wraps modulo 2^32.
  function automatic logic [31:0] victim_pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Fixed-priority select: scanning from the top down lets the lowest set
  // index overwrite any higher one.
  always_comb begin
    exc_any      = 1'b0;
    exc_sel_code = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        exc_any      = 1'b1;
        exc_sel_code = exc_codes[5*i +: 5];
      end
    end
  end

  assign req_any    = exc_any | int_req | eret_m;
  assign req_is_ret = eret_m & ~exc_any & ~int_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      code_q   <= 5'd0;
      vpc_q    <= 32'd0;
      is_ret_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state    <= state_nxt;
      code_q   <= code_nxt;
      vpc_q    <= vpc_nxt;
      is_ret_q <= is_ret_nxt;
      cnt_q    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    code_nxt   = code_q;
    vpc_nxt    = vpc_q;
    is_ret_nxt = is_ret_q;
    cnt_nxt    = cnt_q;
    case (state)
      IDLE: begin
        if (req_any) begin
          // Capture happens only here; DRAIN keeps whatever was latched.
          code_nxt   = exc_any ? exc_sel_code : 5'd0;
          vpc_nxt    = pc_m;
          is_ret_nxt = req_is_ret;
          if (mem_busy)
            state_nxt = DRAIN;
          else
            state_nxt = req_is_ret ? RET : TAKE;
        end
      end
      DRAIN: begin
        if (!mem_busy)
          state_nxt = is_ret_q ? RET : TAKE;
      end
      TAKE, RET: begin
        state_nxt = GUARD;
        cnt_nxt   = CNT_W'(GUARD_CYCLES);
      end
      GUARD: begin
        // Requests are deliberately not looked at: cp0 IntReq lags the
        // EXL update, and re-arbitrating now would retake the same interrupt.
        if (cnt_q <= CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    exl_set     = 1'b0;
    exl_clr     = 1'b0;
    exc_code    = 5'd0;
    cp0_pc      = 32'd0;
    case (state)
      DRAIN: begin
        stall = 1'b1;
      end
      TAKE: begin
        stall       = 1'b1;
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = HANDLER_ADDR;
        exl_set     = 1'b1;
        exc_code    = code_q;
        cp0_pc      = victim_pc_plus4(vpc_q);
      end
      RET: begin
        stall       = 1'b1;
        flush       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_i;
        exl_clr     = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_exc_seq.sv
// tb_exc_seq -- self-checking bench for exc_seq.
// Each request driven pushes the expected redirect transaction onto a
// scoreboard; a negedge monitor pops and compares whenever redirect is high.
module tb_exc_seq;

  logic        clk;
  logic        rst;
  logic [3:0]  exc_req;
  logic [19:0] exc_codes;
  logic        int_req;
  logic        eret_m;
  logic        mem_busy;
  logic [31:0] pc_m;
  logic [31:0] epc_i;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exl_set;
  logic        exl_clr;
  logic [4:0]  exc_code;
  logic [31:0] cp0_pc;

  typedef struct packed {
    logic [31:0] rpc;
    logic        set;
    logic        clr;
    logic [4:0]  code;
    logic [31:0] cpc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  exc_seq #(
    .NSRC(4),
    .HANDLER_ADDR(32'h0000_4180),
    .GUARD_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .exc_req(exc_req),
    .exc_codes(exc_codes),
    .int_req(int_req),
    .eret_m(eret_m),
    .mem_busy(mem_busy),
    .pc_m(pc_m),
    .epc_i(epc_i),
    .stall(stall),
    .flush(flush),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .exl_set(exl_set),
    .exl_clr(exl_clr),
    .exc_code(exc_code),
    .cp0_pc(cp0_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    exc_req  = 4'b0000;
    int_req  = 1'b0;
    eret_m   = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic drain_sb(input string tag);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      step();
      t++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: every redirect must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && redirect) begin
      if (sb.size() == 0) begin
        chk("unexpected_redirect", 64'(redirect), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("redirect_pc", 64'(redirect_pc), 64'(mon_e.rpc));
        chk("exl_set",     64'(exl_set),     64'(mon_e.set));
        chk("exl_clr",     64'(exl_clr),     64'(mon_e.clr));
        chk("exc_code",    64'(exc_code),    64'(mon_e.code));
        chk("cp0_pc",      64'(cp0_pc),      64'(mon_e.cpc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    clear_req();
    exc_codes = 20'd0;
    pc_m      = 32'd0;
    epc_i     = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall",       64'(stall),       64'd0);
    chk("rst_flush",       64'(flush),       64'd0);
    chk("rst_redirect",    64'(redirect),    64'd0);
    chk("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    chk("rst_exl_set",     64'(exl_set),     64'd0);
    chk("rst_exl_clr",     64'(exl_clr),     64'd0);
    chk("rst_exc_code",    64'(exc_code),    64'd0);
    chk("rst_cp0_pc",      64'(cp0_pc),      64'd0);

    // 1: reset while draining aborts the sequence
    step();
    rst = 1'b0;
    step();
    int_req  = 1'b1;
    mem_busy = 1'b1;
    pc_m     = 32'h0000_1000;
    step();
    int_req = 1'b0;
    @(negedge clk);
    chk("t1_drain_stall", 64'(stall), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_stall", 64'(stall), 64'd0);
    chk("t1_rst_flush", 64'(flush), 64'd0);
    step();
    step();
    rst      = 1'b0;
    mem_busy = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t1_no_exl_set", 64'(exl_set), 64'd0);
      chk("t1_idle_stall", 64'(stall),   64'd0);
    end

    // 2: two exceptions, lowest index wins
    step();
    exc_req           = 4'b0110;
    exc_codes[9:5]    = 5'd4;
    exc_codes[14:10]  = 5'd10;
    pc_m              = 32'h0000_3010;
    sb.push_back(exp_t'{32'h0000_4180, 1'b1, 1'b0, 5'd4, 32'h0000_3014});
    step();
    clear_req();
    @(negedge clk);
    chk("t2_flush", 64'(flush), 64'd1);
    chk("t2_stall", 64'(stall), 64'd1);
    step();
    @(negedge clk);
    chk("t2_guard_stall",    64'(stall),    64'd0);
    chk("t2_guard_redirect", 64'(redirect), 64'd0);
    repeat (3) step();
    drain_sb("t2_sb_drained");

    // 3: interrupt waits out a busy bus, then guard ignores lingering int_req
    step();
    int_req  = 1'b1;
    mem_busy = 1'b1;
    pc_m     = 32'h0000_2000;
    sb.push_back(exp_t'{32'h0000_4180, 1'b1, 1'b0, 5'd0, 32'h0000_2004});
    for (int i = 0; i < 3; i++) begin
      step();
      pc_m = 32'h0000_5000;
      if (i == 2) mem_busy = 1'b0;
      @(negedge clk);
      chk("t3_drain_stall",   64'(stall), 64'd1);
      chk("t3_drain_noflush", 64'(flush), 64'd0);
    end
    step();
    @(negedge clk);
    chk("t3_take_flush", 64'(flush), 64'd1);
    step();
    @(negedge clk);
    chk("t3_guard1_redirect", 64'(redirect), 64'd0);
    chk("t3_guard1_stall",    64'(stall),    64'd0);
    step();
    int_req = 1'b0;
    @(negedge clk);
    chk("t3_guard2_redirect", 64'(redirect), 64'd0);
    step();
    @(negedge clk);
    chk("t3_idle_stall", 64'(stall), 64'd0);
    drain_sb("t3_sb_drained");

    // 4: ERET redirects to EPC
    step();
    eret_m = 1'b1;
    epc_i  = 32'h0000_3020;
    pc_m   = 32'h0000_3100;
    sb.push_back(exp_t'{32'h0000_3020, 1'b0, 1'b1, 5'd0, 32'h0000_0000});
    step();
    eret_m = 1'b0;
    @(negedge clk);
    chk("t4_flush",   64'(flush),   64'd1);
    chk("t4_exl_set", 64'(exl_set), 64'd0);
    repeat (3) step();
    drain_sb("t4_sb_drained");

    // 5: interrupt beats a simultaneous ERET
    step();
    int_req = 1'b1;
    eret_m  = 1'b1;
    pc_m    = 32'h0000_3200;
    sb.push_back(exp_t'{32'h0000_4180, 1'b1, 1'b0, 5'd0, 32'h0000_3204});
    step();
    clear_req();
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_exl_clr", 64'(exl_clr), 64'd0);
      step();
    end
    drain_sb("t5_sb_drained");

    // 6: exception beats interrupt; cp0_pc wraps
    step();
    exc_req           = 4'b1000;
    exc_codes[19:15]  = 5'd13;
    int_req           = 1'b1;
    pc_m              = 32'hFFFF_FFFC;
    sb.push_back(exp_t'{32'h0000_4180, 1'b1, 1'b0, 5'd13, 32'h0000_0000});
    step();
    clear_req();
    @(negedge clk);
    chk("t6_flush", 64'(flush), 64'd1);
    repeat (4) step();
    drain_sb("t6_sb_drained");

    // Quiet idle
    @(negedge clk);
    chk("idle_stall",    64'(stall),    64'd0);
    chk("idle_redirect", 64'(redirect), 64'd0);
    chk("idle_cp0_pc",   64'(cp0_pc),   64'd0);
    chk("idle_exc_code", 64'(exc_code), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
